iterative_mul_div: RTL and testbench
====================================

# iterative_mul_div

- Multi-cycle integer multiply/divide unit in the execute stage, fed by the register array's read ports (`reg1`, `reg2`).
- Computes one result per operation using an iterative shift-add (multiply) or restoring (divide) algorithm.
- Writes the result back through a single-cycle word-write beat that drives the register array's `write_reg_address`, `write_data` and `write_word_enable` inputs directly.

## Interface
- `WIDTH`, 32, operand and result width
- `REG_ADDR_W`, 5, destination register address width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only when `busy`=0
- `op`  in  2  00 MUL (low word), 01 MULH (high word), 10 DIV (quotient), 11 REM (remainder)
- `op_signed`  in  1  signed interpretation; used only with `MULDIV_SIGNED_EN`
- `operand_a`  in  WIDTH  multiplicand / dividend (from `reg1`)
- `operand_b`  in  WIDTH  multiplier / divisor (from `reg2`)
- `dest_addr`  in  REG_ADDR_W  destination register
- `busy`  out  1  high from the cycle after acceptance through the WB cycle
- `done`  out  1  one-cycle pulse, coincident with the write beat
- `write_reg_address`  out  REG_ADDR_W  latched `dest_addr`
- `write_data`  out  WIDTH  result
- `write_word_enable`  out  1  one-cycle write strobe to the register array

## Operation
- FSM states and transitions:
  - IDLE: on `start`=1, latch `op`, `op_signed`, operands and `dest_addr`; go to CALC.
  - CALC: runs exactly WIDTH iterations, counted by a `$clog2(WIDTH)+1`-bit counter; after the last iteration go to WB.
  - WB: drive the result, `write_word_enable`=1, `done`=1; return to IDLE.
- `start` in CALC or WB: ignored. No queueing and no abort.
- Input latching: operand inputs are sampled only at acceptance; later changes have no effect.
- Multiply:
  - 2·WIDTH product register; one conditional add of the multiplicand plus one shift per iteration.
  - MUL returns `product[WIDTH-1:0]`; MULH returns `product[2*WIDTH-1:WIDTH]`.
- Divide:
  - Restoring algorithm; each iteration shifts the remainder left by one, subtracts the divisor (WIDTH+1-bit compare), and on a non-negative result keeps the difference and sets the quotient bit.
- Divide by zero (`operand_b`=0), regardless of signedness:
  - quotient = all ones;
  - remainder = `operand_a`;
  - still takes the full CALC duration.
- Unsigned operation is the default whenever `MULDIV_SIGNED_EN` is not defined.
- All output values are held between write beats; `write_data` keeps the last result.

## Timing
- Acceptance edge is cycle 0.
- CALC occupies cycles 1..WIDTH.
- WB is cycle WIDTH+1, so with defaults `write_word_enable`/`done` are high for exactly one cycle, 33 cycles after acceptance.
- IDLE is re-entered at cycle WIDTH+2; a new `start` can be accepted on that edge. Throughput is one op per WIDTH+2 cycles.
- `busy` is asserted from cycle 1 through cycle WIDTH+1.
- Reset (`rst`=0, asynchronous):
  - state → IDLE, counter 0;
  - `busy`, `done`, `write_word_enable` = 0;
  - `write_data` = 0, `write_reg_address` = 0.
- Reset asserted mid-CALC or during WB aborts the op; no write beat is produced, even if WB was already in progress.
- Writes to register 0 are not filtered here.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - `op_signed`=1 selects two's-complement operation. Operands are converted to magnitudes at acceptance, and the sign is fixed up in WB.
  - MULH returns the signed high word.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Overflow case (most-negative / −1) gives quotient = most-negative, remainder = 0.
  - Divide by zero behaves as in Operation.
- Not defined: `op_signed` is ignored, all ops are unsigned, and no sign-fixup logic is synthesized.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings (`OP_MUL`, `OP_MULH`, `OP_DIV`, `OP_REM`);
  - the FSM state typedef (IDLE, CALC, WB).
- One natural sub-module, `muldiv_step`: combinational single iteration. It takes the accumulator, operand and op class, and returns the next accumulator plus the quotient bit.
- The FSM, counter, latches and sign handling stay in `iterative_mul_div`.

## Test plan
- MUL 7 × 6, dest 3 → after 33 cycles, one write beat: addr 3, data 42, `done`=1; `busy` low next cycle.
- MULH 0xFFFF_FFFF × 0xFFFF_FFFF unsigned → write data 0xFFFF_FFFE.
- DIV 100 / 7 → 14; REM 100 / 7 → 2; back-to-back ops accepted on cycle WIDTH+2 with no lost beat.
- DIV 5 / 0 → 0xFFFF_FFFF; REM 5 / 0 → 5; latency unchanged.
- `rst` pulsed low at cycle 10 of CALC → all outputs 0 immediately, no write beat; a `start` pulsed while `busy`=1 produces no second write beat.
- With `MULDIV_SIGNED_EN`:
  - signed DIV −7 / 2 → 0xFFFF_FFFD (−3); signed REM −7 / 2 → 0xFFFF_FFFF (−1);
  - signed DIV 0x8000_0000 / −1 → 0x8000_0000.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM state type and the per-iteration op class.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        WB   = 2'b10
    } state_t;

    typedef enum logic {
        CLASS_MUL = 1'b0,
        CLASS_DIV = 1'b1
    } op_class_t;

    // DIV and REM share the divider datapath; MUL and MULH share the multiplier.
    function automatic op_class_t op_class(input logic [1:0] op);
        return op[1] ? CLASS_DIV : CLASS_MUL;
    endfunction

endpackage

// File: rtl/iterative_mul_div_if.sv
// Request / write-back bundle between the execute stage and the mul/div unit.
// master drives requests, slave is the unit itself.
interface iterative_mul_div_if #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  start;
    logic [1:0]            op;
    logic                  op_signed;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [REG_ADDR_W-1:0] dest_addr;
    logic                  busy;
    logic                  done;
    logic [REG_ADDR_W-1:0] write_reg_address;
    logic [WIDTH-1:0]      write_data;
    logic                  write_word_enable;

    modport master (
        output start, op, op_signed, operand_a, operand_b, dest_addr,
        input  busy, done, write_reg_address, write_data, write_word_enable
    );

    modport slave (
        input  start, op, op_signed, operand_a, operand_b, dest_addr,
        output busy, done, write_reg_address, write_data, write_word_enable
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// The divide quotient bit is returned separately; acc_next[0] is left 0 for divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  op_class_t          op_cls,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_trial;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
        // Remainder after the left shift is WIDTH+1 bits wide, hence the wide compare.
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        acc_next  = '0;
        q_bit     = 1'b0;
        if (op_cls == CLASS_DIV) begin
            q_bit = ~div_trial[WIDTH];
            if (q_bit)
                acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iterative_mul_div.sv
// Iterative multiply/divide unit with single-beat register write-back.
// Define MULDIV_SIGNED_EN to add two's-complement operation via op_signed.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on acceptance
// CALC  | WIDTH iterations of muldiv_step, down-counted
// WB    | result on write_data, write_word_enable/done high
module iterative_mul_div
    import muldiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic                clk,
    input logic                rst,
    iterative_mul_div_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            op_q;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [2*WIDTH-1:0]    acc;
    logic [WIDTH-1:0]      operand_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wen_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [WIDTH-1:0]      wdata_q;

    logic [WIDTH-1:0]      a_mag;
    logic [WIDTH-1:0]      b_mag;
    logic [2*WIDTH-1:0]    step_acc;
    logic                  step_q;
    logic [2*WIDTH-1:0]    next_acc;
    logic [2*WIDTH-1:0]    prod;
    logic [WIDTH-1:0]      quo;
    logic [WIDTH-1:0]      rem;
    logic [WIDTH-1:0]      result;

`ifdef MULDIV_SIGNED_EN
    logic neg_q;
    logic rem_neg_q;
    logic b_zero_q;
`else
    logic unused_op_signed;
    assign unused_op_signed = bus.op_signed;
`endif

    always_comb begin
        a_mag = bus.operand_a;
        b_mag = bus.operand_b;
`ifdef MULDIV_SIGNED_EN
        if (bus.op_signed) begin
            if (bus.operand_a[WIDTH-1]) a_mag = -bus.operand_a;
            if (bus.operand_b[WIDTH-1]) b_mag = -bus.operand_b;
        end
`endif
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (operand_q),
        .op_cls   (op_class(op_q)),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    assign next_acc = {step_acc[2*WIDTH-1:1],
                       (op_class(op_q) == CLASS_DIV) ? step_q : step_acc[0]};

    // Result is formed from the last iteration's output so WB can register it directly.
    always_comb begin
        prod = next_acc;
        quo  = next_acc[WIDTH-1:0];
        rem  = next_acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
        if (neg_q) prod = -prod;
        if (neg_q && !b_zero_q) quo = -quo;
        if (rem_neg_q) rem = -rem;
`endif
        case (op_q)
            OP_MUL:  result = prod[WIDTH-1:0];
            OP_MULH: result = prod[2*WIDTH-1:WIDTH];
            OP_DIV:  result = quo;
            default: result = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            dest_q    <= '0;
            acc       <= '0;
            operand_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= CALC;
                        busy_q    <= 1'b1;
                        cnt       <= CNT_W'(WIDTH);
                        op_q      <= bus.op;
                        dest_q    <= bus.dest_addr;
                        if (op_class(bus.op) == CLASS_DIV) begin
                            acc       <= {{WIDTH{1'b0}}, a_mag};
                            operand_q <= b_mag;
                        end else begin
                            acc       <= {{WIDTH{1'b0}}, b_mag};
                            operand_q <= a_mag;
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_q     <= bus.op_signed & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                        rem_neg_q <= bus.op_signed & bus.operand_a[WIDTH-1];
                        b_zero_q  <= (bus.operand_b == '0);
`endif
                    end
                end
                CALC: begin
                    acc <= next_acc;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= WB;
                        wdata_q <= result;
                        waddr_q <= dest_q;
                        wen_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                WB: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    wen_q  <= 1'b0;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.write_word_enable = wen_q;
    assign bus.write_reg_address = waddr_q;
    assign bus.write_data        = wdata_q;

endmodule

// File: tb/tb_iterative_mul_div.sv
// Directed-vector bench for iterative_mul_div; signed vectors are added when
// MULDIV_SIGNED_EN is defined, otherwise op_signed is checked to be ignored.
module tb_iterative_mul_div;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   beats = 0;

    always #5 clk = ~clk;

    iterative_mul_div_if #(.WIDTH(32), .REG_ADDR_W(5)) bus ();

    iterative_mul_div #(.WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) if (bus.write_word_enable) beats++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one op, scrambles the inputs after acceptance, and checks the beat.
    // With poke set, start is pulsed mid-CALC and must not cause a second beat.
    task automatic run_op(input string tag, input logic [1:0] op, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, input logic [31:0] exp, input bit poke);
        int cyc;
        int b0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = op;
        bus.op_signed = sg;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_addr = dest;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.op        = ~op;
        bus.operand_a = ~a;
        bus.operand_b = b + 32'd3;
        bus.dest_addr = ~dest;
        cyc = 1;
        b0  = beats;
        check({tag, " busy_c1"}, 64'(bus.busy), 64'd1);
        while (!bus.write_word_enable && cyc < 60) begin
            bus.start = (poke && cyc == 10);
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'd33);
        check({tag, " data"}, 64'(bus.write_data), 64'(exp));
        check({tag, " addr"}, 64'(bus.write_reg_address), 64'(dest));
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " busy_wb"}, 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        check({tag, " wen_low"}, 64'(bus.write_word_enable), 64'd0);
        check({tag, " busy_low"}, 64'(bus.busy), 64'd0);
        check({tag, " beats"}, 64'(beats - b0), 64'd1);
        check({tag, " held"}, 64'(bus.write_data), 64'(exp));
        if (poke) begin
            repeat (40) @(posedge clk);
            #1;
            check({tag, " no_extra_beat"}, 64'(beats - b0), 64'd1);
            check({tag, " idle_after_poke"}, 64'(bus.busy), 64'd0);
        end
    endtask

    initial begin
        int b0;
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.op_signed = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_addr = '0;
        #12;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset wen", 64'(bus.write_word_enable), 64'd0);
        check("reset data", 64'(bus.write_data), 64'd0);
        check("reset addr", 64'(bus.write_reg_address), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mul7x6",     2'b00, 1'b0, 32'd7,          32'd6,          5'd3, 32'd42,         1'b0);
        run_op("mulh_ff",    2'b01, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4, 32'hFFFF_FFFE,  1'b0);
        run_op("mul_ff",     2'b00, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5, 32'h0000_0001,  1'b0);
        run_op("div100_7",   2'b10, 1'b0, 32'd100,        32'd7,          5'd6, 32'd14,         1'b0);
        run_op("rem100_7",   2'b11, 1'b0, 32'd100,        32'd7,          5'd7, 32'd2,          1'b0);
        run_op("div5_0",     2'b10, 1'b0, 32'd5,          32'd0,          5'd8, 32'hFFFF_FFFF,  1'b0);
        run_op("rem5_0",     2'b11, 1'b0, 32'd5,          32'd0,          5'd9, 32'd5,          1'b0);
        run_op("mul_shift",  2'b00, 1'b0, 32'h1234_5678,  32'h10,         5'd10, 32'h2345_6780, 1'b0);
        run_op("mulh_shift", 2'b01, 1'b0, 32'h1234_5678,  32'h10,         5'd11, 32'h0000_0001, 1'b0);
        run_op("div_big",    2'b10, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h0,         1'b0);
        run_op("rem_big",    2'b11, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000, 1'b0);
        run_op("wr_reg0",    2'b00, 1'b0, 32'd9,          32'd9,          5'd0, 32'd81,         1'b0);
`ifdef MULDIV_SIGNED_EN
        run_op("sdiv-7_2",   2'b10, 1'b1, 32'hFFFF_FFF9,  32'd2,          5'd14, 32'hFFFF_FFFD, 1'b0);
        run_op("srem-7_2",   2'b11, 1'b1, 32'hFFFF_FFF9,  32'd2,          5'd15, 32'hFFFF_FFFF, 1'b0);
        run_op("sdiv_ovf",   2'b10, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'h8000_0000, 1'b0);
        run_op("srem_ovf",   2'b11, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h0,         1'b0);
        run_op("smul-3_5",   2'b00, 1'b1, 32'hFFFF_FFFD,  32'd5,          5'd18, 32'hFFFF_FFF1, 1'b0);
        run_op("smulh-3_5",  2'b01, 1'b1, 32'hFFFF_FFFD,  32'd5,          5'd19, 32'hFFFF_FFFF, 1'b0);
        run_op("smulh-1-1",  2'b01, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd20, 32'h0,         1'b0);
        run_op("sdiv-5_0",   2'b10, 1'b1, 32'hFFFF_FFFB,  32'd0,          5'd21, 32'hFFFF_FFFF, 1'b0);
        run_op("srem-5_0",   2'b11, 1'b1, 32'hFFFF_FFFB,  32'd0,          5'd22, 32'hFFFF_FFFB, 1'b0);
`else
        run_op("sg_ign_div", 2'b10, 1'b1, 32'hFFFF_FFF9,  32'd2,          5'd14, 32'h7FFF_FFFC, 1'b0);
        run_op("sg_ign_mulh",2'b01, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd15, 32'hFFFF_FFFE, 1'b0);
`endif
        run_op("poke_busy",  2'b00, 1'b0, 32'd3,          32'd5,          5'd23, 32'd15,        1'b1);

        // Asynchronous reset in the middle of CALC: outputs clear at once, no beat follows.
        @(negedge clk);
        bus.start     = 1'b1;
        bus.op        = 2'b00;
        bus.op_signed = 1'b0;
        bus.operand_a = 32'd7;
        bus.operand_b = 32'd6;
        bus.dest_addr = 5'd24;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        b0  = beats;
        rst = 1'b0;
        #1;
        check("rst_mid busy", 64'(bus.busy), 64'd0);
        check("rst_mid done", 64'(bus.done), 64'd0);
        check("rst_mid wen", 64'(bus.write_word_enable), 64'd0);
        check("rst_mid data", 64'(bus.write_data), 64'd0);
        check("rst_mid addr", 64'(bus.write_reg_address), 64'd0);
        #2;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid no_beat", 64'(beats - b0), 64'd0);
        check("rst_mid idle", 64'(bus.busy), 64'd0);

        run_op("after_rst",  2'b00, 1'b0, 32'd2,          32'd3,          5'd1, 32'd6,          1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
